imem_loader: RTL
================

# imem_loader

Instruction-memory responder for the IF stage: a synchronous single-port instruction SRAM with a streaming program-load front end. A valid/ready word stream fills the SRAM. Once loading completes, the block asserts the run enable that drives the IF stage `Start` input. In run mode it answers IF-stage read requests with one-cycle read latency.

## Interface
Parameters
- INST_ADDR_WIDTH, default 10 (cpu_pkg value): word-address width; DEPTH = 2**INST_ADDR_WIDTH words.
- INST_DATA_WIDTH, default 32: instruction word width.

Ports
- Clk  in  1  clock; all state updates on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Ld_Start_i  in  1  single-cycle pulse that begins or restarts a program load.
- Ld_Valid_i  in  1  load word valid.
- Ld_Data_i  in  INST_DATA_WIDTH  load word.
- Ld_Last_i  in  1  marks the final word of the program; qualified by Ld_Valid_i.
- Ld_Ready_o  out  1  block accepts load words.
- Ld_Count_o  out  INST_ADDR_WIDTH+1  number of words written in the current or last load.
- Ld_Err_o  out  1  overflow: DEPTH words were accepted without Ld_Last_i.
- Start_o  out  1  run enable to the IF stage `Start` input.
- Imem_En_i  in  1  read request from the IF stage.
- Imem_Addr_i  in  INST_ADDR_WIDTH  word address from the IF stage (PC[INST_ADDR_WIDTH+1:2]).
- Imem_Data_o  out  INST_DATA_WIDTH  read data to the IF stage.

## Operation
The FSM has four states: IDLE, LOAD, RUN, ERROR. Reset enters IDLE.

- IDLE: Ld_Ready_o=0, Start_o=0. Ld_Start_i moves to LOAD.
- LOAD: Ld_Ready_o=1.
  - Each handshake (Ld_Valid_i && Ld_Ready_o) writes Ld_Data_i to mem[wr_ptr], then increments wr_ptr and Ld_Count_o.
  - A handshake with Ld_Last_i=1 writes its word and moves to RUN.
  - A handshake at wr_ptr=DEPTH-1 with Ld_Last_i=0 writes its word, sets Ld_Err_o=1, and moves to ERROR.
  - If both Ld_Last_i=1 and wr_ptr=DEPTH-1, the handshake is a normal completion: go to RUN, no error.
- RUN: Start_o=1, Ld_Ready_o=0. Read requests are served (see Timing).
- ERROR: Start_o=0, Ld_Ready_o=0. Only Ld_Start_i leaves this state.
- Ld_Start_i in any state:
  - moves to LOAD;
  - clears wr_ptr, Ld_Count_o and Ld_Err_o;
  - has priority over a handshake in the same cycle, so that word is not written.
  - In RUN, Start_o drops on the same edge.
- Reads occur only in RUN, so writes and reads never collide.
- Imem_En_i outside RUN is ignored and Imem_Data_o holds its value.
- The memory array is not reset. Locations not written by the current load read as stale or X.
- wr_ptr is INST_ADDR_WIDTH bits and never wraps; overflow always goes to ERROR.
- Ld_Count_o saturates at DEPTH.

## Timing
- Reset values: Ld_Ready_o=0, Start_o=0, Ld_Err_o=0, Ld_Count_o=0, Imem_Data_o=0, state IDLE.
- Ld_Start_i at edge N gives Ld_Ready_o=1 from cycle N+1.
- Load throughput is one word per cycle while Ld_Valid_i=1.
- The last-word handshake at edge M gives Start_o=1 and Ld_Ready_o=0 from cycle M+1. The word written at edge M is readable by a request at edge M+1.
- Read latency is 1 cycle: Imem_En_i && RUN at edge K gives Imem_Data_o=mem[Imem_Addr_i] after edge K.
- Imem_Data_o holds when Imem_En_i=0. This matches IF-stage stall behaviour, where the PC and the pipe hold while not ready.
- Ld_Err_o is asserted from the cycle after the overflow handshake and stays high until the next Ld_Start_i.
- Reset asserted mid-load or mid-run returns all outputs to reset values immediately (asynchronous). Memory contents persist.

## Test plan
- Basic load, INST_ADDR_WIDTH=4:
  - Stimulus: Ld_Start_i, then 3 back-to-back words 0x00000013, 0x00100093, 0x00208113, with Ld_Last_i on the third.
  - Required: Ld_Count_o=3 and Start_o=1 the cycle after the third handshake. Reads of addresses 0,1,2 return those words one cycle after Imem_En_i.
- Backpressure and gaps:
  - Stimulus: Ld_Valid_i toggled 1,0,0,1,1 while loading.
  - Required: only the 3 valid-high cycles write; Ld_Count_o=3; the words land at addresses 0..2 in order.
- Overflow:
  - Stimulus: 16 words with no Ld_Last_i.
  - Required: Ld_Err_o=1, state ERROR, Start_o=0, Ld_Ready_o=0, Ld_Count_o=16. A 17th Ld_Valid_i is not accepted.
- Exact fill:
  - Stimulus: 16 words with Ld_Last_i on word 16.
  - Required: Ld_Err_o=0, Start_o=1, address 15 reads word 16.
- Restart:
  - Stimulus: in RUN, Ld_Start_i coincides with Imem_En_i and Ld_Valid_i.
  - Required: Start_o=0 next cycle, Ld_Count_o=0, no write, Imem_Data_o unchanged. A following 1-word load sets Start_o=1 again.
- Stall hold and async reset:
  - Stimulus: in RUN, read address 2, then Imem_En_i=0 for 3 cycles.
  - Required: Imem_Data_o stays mem[2].
  - Stimulus: Rst_n low mid-cycle.
  - Required: Start_o=0 and Imem_Data_o=0 before the next clock edge.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory for the IF stage: a valid/ready word stream fills a single-port SRAM,
// then the block raises the IF-stage run enable and serves one-cycle-latency reads.
module imem_loader #(
  parameter int INST_ADDR_WIDTH = 10,
  parameter int INST_DATA_WIDTH = 32
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Ld_Start_i,
  input  logic                       Ld_Valid_i,
  input  logic [INST_DATA_WIDTH-1:0] Ld_Data_i,
  input  logic                       Ld_Last_i,
  output logic                       Ld_Ready_o,
  output logic [INST_ADDR_WIDTH:0]   Ld_Count_o,
  output logic                       Ld_Err_o,
  output logic                       Start_o,
  input  logic                       Imem_En_i,
  input  logic [INST_ADDR_WIDTH-1:0] Imem_Addr_i,
  output logic [INST_DATA_WIDTH-1:0] Imem_Data_o
);

  localparam int DEPTH = 2 ** INST_ADDR_WIDTH;
  localparam logic [INST_ADDR_WIDTH:0] CNT_ONE = {{INST_ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_t;

  state_t                     state_q;
  logic [INST_ADDR_WIDTH:0]   count_q;
  logic [INST_ADDR_WIDTH:0]   count_d;
  logic                       ready_q;
  logic                       start_q;
  logic                       err_q;
  logic [INST_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [INST_DATA_WIDTH-1:0] rdata_q;

  logic [INST_ADDR_WIDTH-1:0] wr_ptr;
  logic                       at_end;
  logic                       wr_en;
  logic                       rd_en;

  // The write pointer is the low bits of the word count; the count only reaches DEPTH
  // after the final slot is written, at which point the FSM has already left LOAD.
  assign wr_ptr  = count_q[INST_ADDR_WIDTH-1:0];
  assign at_end  = &wr_ptr;
  assign count_d = count_q + CNT_ONE;

  // ready_q is high exactly in LOAD and start_q exactly in RUN; a load start wins over both.
  assign wr_en = ready_q && Ld_Valid_i && !Ld_Start_i;
  assign rd_en = start_q && Imem_En_i && !Ld_Start_i;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (Ld_Start_i) begin
      state_q <= LOAD;
      count_q <= '0;
      ready_q <= 1'b1;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (state_q == LOAD && Ld_Valid_i) begin
      count_q <= count_d;
      if (Ld_Last_i) begin
        state_q <= RUN;
        ready_q <= 1'b0;
        start_q <= 1'b1;
      end else if (at_end) begin
        state_q <= ERROR;
        ready_q <= 1'b0;
        err_q   <= 1'b1;
      end
    end
  end

  // Array carries no reset so it maps onto block RAM; contents survive Rst_n.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= Ld_Data_i;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem_q[Imem_Addr_i];
    end
  end

  assign Ld_Ready_o  = ready_q;
  assign Ld_Count_o  = count_q;
  assign Ld_Err_o    = err_q;
  assign Start_o     = start_q;
  assign Imem_Data_o = rdata_q;

endmodule
